ram_rd_chk: RTL and testbench
=============================

Name: ram_rd_chk

Overview:
- Downstream consumer of the dual-port RAM read port (port B).
- On each start request from the RAM writer (rd_flag rising edge), sweeps the whole RAM once and compares every returned word with the known write pattern.
- Reports per-pass completion, a sticky error flag, a saturating error count and the first failing address.
- Sits beside the RAM in the top level and drives enb/addrb/doutb in place of a plain reader; probe outputs go to the ILA.

Parameters:
- ADDR_W, 6, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 64, words swept per pass; 1..2^ADDR_W.
- RD_LAT, 1, RAM read latency in clocks from en/addr to valid dout; 1..3.
- BASE, 0, pattern offset; expected(a) = (BASE + a) mod 2^DATA_W.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- rd_flag  in  1  start request from writer; only the rising edge is used.
- ram_rd_en  out  1  RAM port B enable.
- ram_rd_addr  out  ADDR_W  RAM port B address.
- ram_rd_data  in  DATA_W  RAM port B read data.
- chk_busy  out  1  high from pass start through DONE.
- chk_done  out  1  one-cycle pulse at end of each pass.
- err_flag  out  1  sticky; any mismatch since reset.
- err_cnt  out  16  mismatches since reset; saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of first mismatch since reset.
- ovr_flag  out  1  sticky; start edge arrived while busy.

Behaviour:
- Reset (rst high at a clk edge): all outputs 0.
  - FSM to IDLE; latency pipeline cleared; rd_flag edge register cleared to 0.
  - A flag already high when reset releases produces no start.
- Edge detect: start = rd_flag & ~rd_flag_q, with rd_flag_q registered every cycle.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on start -> READ; addr counter = 0; chk_busy = 1 from the next cycle.
  - READ: ram_rd_en = 1, ram_rd_addr = counter; counter increments every cycle.
    - On counter == DEPTH-1 the issue completes -> DRAIN.
    - Exactly DEPTH consecutive enable cycles, addresses 0..DEPTH-1 in order.
  - DRAIN: ram_rd_en = 0; ram_rd_addr holds the last value; wait until the pipeline is empty -> DONE.
  - DONE: chk_done = 1 for one cycle; chk_busy = 0 from the following cycle; -> IDLE.
- Latency alignment:
  - RD_LAT-deep shift register of {valid, addr}; valid = ram_rd_en.
  - When the output stage is valid, compare ram_rd_data with expected(stage addr).
  - ram_rd_data is ignored whenever the stage is not valid.
- Mismatch handling:
  - err_cnt increments (saturating).
  - err_flag is set.
  - If err_flag was 0, first_err_addr captures the stage addr; later errors never overwrite it.
- Simultaneous: a mismatch in the same cycle as saturation leaves err_cnt at FFFF.
- Start edge in READ/DRAIN/DONE: ignored (no restart, no queueing); ovr_flag is set.
- Widths: expected computed at DATA_W with wrap; counter ADDR_W bits, no wrap beyond DEPTH-1.
- Pass timeline from the start edge: busy for DEPTH + RD_LAT + 1 cycles; chk_done at cycle DEPTH+RD_LAT+1 counting the first READ cycle as 1.
- rst mid-pass: immediate abort to IDLE, counters and flags cleared, pipeline flushed; no chk_done.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=0, READ=1, DRAIN=2, DONE=3);
  - the pattern function expected(addr, BASE);
  - the ERR_CNT_W = 16 constant.
- The same pattern function is reused by the RAM writer.
- One natural sub-module: ram_lat_pipe, a parameterised RD_LAT-deep valid/addr delay line.

Test Plan:
- Clean pass: RAM preloaded with a = data, single rd_flag edge -> 64 enables at addr 0..63, chk_done after 66 cycles, err_cnt = 0, err_flag = 0.
- Fault injection: RAM words 5 and 40 corrupted to 8'hFF -> err_cnt = 2, first_err_addr = 5, err_flag = 1; second clean pass leaves err_cnt = 2 and first_err_addr = 5.
- Latency: RD_LAT = 2 with a 2-stage RAM model -> zero errors, chk_done 67 cycles after start; RD_LAT = 1 against the same model -> nonzero errors (misalignment detected).
- Overrun: second rd_flag edge at READ cycle 10 -> pass unaffected, ovr_flag = 1, exactly one chk_done.
- Reset mid-pass: rst at READ cycle 20 -> next cycle ram_rd_en = 0, all outputs 0, no chk_done; rd_flag held high across reset gives no start until it falls and rises again.
- Saturation: force err_cnt near max (DEPTH = 64, all words wrong, 1024+ passes, or preload via a test hook) -> err_cnt holds at FFFF, no wrap.

Source files
------------

// File: rtl/ram_rd_chk_pkg.sv
// Shared definitions for the RAM read checker and the RAM writer:
// FSM state encoding, the test-pattern function and the error-counter width.
package ram_rd_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  localparam int ERR_CNT_W = 16;

  // Pattern word stored at address addr. Callers mask the result down to
  // their data width, which gives the mod 2^DATA_W wrap.
  function automatic logic [31:0] expected(input logic [31:0] addr,
                                           input logic [31:0] base);
    return base + addr;
  endfunction

endpackage

// File: rtl/ram_lat_pipe.sv
// RD_LAT-deep delay line of {valid, addr}. The output stage lines up with
// the RAM read data of the request that produced it. pend is high while any
// stage other than the output stage still holds a valid entry.
module ram_lat_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pend
);

  logic              valid_q [RD_LAT];
  logic [ADDR_W-1:0] addr_q  [RD_LAT];

  // Shift the request tag one stage per clock; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_addr  = addr_q[RD_LAT-1];

  // Entries still in flight ahead of the output stage.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pend = pend | valid_q[i];
    end
  end

endmodule

// File: rtl/ram_rd_chk.sv
// RAM read-port checker: on each rd_flag rising edge it sweeps addresses
// 0..DEPTH-1 once, compares each returned word with the write pattern and
// keeps sticky error status, a saturating error count and the first bad
// address. Handshake: ram_rd_en/ram_rd_addr issue a read every cycle the
// enable is high; ram_rd_data is taken as valid exactly RD_LAT clocks later
// and is ignored at all other times (no back-pressure).
module ram_rd_chk
  import ram_rd_chk_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1,
  parameter int BASE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_flag,
  output logic                 ram_rd_en,
  output logic [ADDR_W-1:0]    ram_rd_addr,
  input  logic [DATA_W-1:0]    ram_rd_data,
  output logic                 chk_busy,
  output logic                 chk_done,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic                 ovr_flag
);

  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [31:0]          DATA_MASK = 32'((64'd1 << DATA_W) - 64'd1);

  chk_state_t        state;
  logic              rd_flag_q;
  logic              armed;
  logic              start;
  logic              pipe_valid;
  logic [ADDR_W-1:0] pipe_addr;
  logic              pipe_pend;
  logic [31:0]       exp_word;
  logic              mismatch;

  // armed stays low for the first cycle after reset so that a flag already
  // high when reset releases is not mistaken for a fresh rising edge.
  assign start = rd_flag & ~rd_flag_q & armed;

  // Edge-detect history for rd_flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_flag_q <= 1'b0;
      armed     <= 1'b0;
    end else begin
      rd_flag_q <= rd_flag;
      armed     <= 1'b1;
    end
  end

  ram_lat_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (ram_rd_en),
    .in_addr   (ram_rd_addr),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .pend      (pipe_pend)
  );

  assign exp_word = expected(32'(pipe_addr), 32'(BASE)) & DATA_MASK;
  assign mismatch = pipe_valid && (32'(ram_rd_data) != exp_word);

  // Sweep FSM with registered outputs; restart requests while busy only
  // raise ovr_flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      chk_busy    <= 1'b0;
      chk_done    <= 1'b0;
      ovr_flag    <= 1'b0;
    end else begin
      if (start && state != ST_IDLE) ovr_flag <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_READ;
            ram_rd_en   <= 1'b1;
            ram_rd_addr <= '0;
            chk_busy    <= 1'b1;
          end
        end
        ST_READ: begin
          if (ram_rd_addr == LAST_ADDR) begin
            state     <= ST_DRAIN;
            ram_rd_en <= 1'b0;
          end else begin
            ram_rd_addr <= ram_rd_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // The output stage is compared this cycle; leave once nothing
          // remains behind it.
          if (!pipe_pend) begin
            state    <= ST_DONE;
            chk_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          chk_done <= 1'b0;
          chk_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Error bookkeeping on every valid compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      err_flag <= 1'b1;
      if (err_cnt != CNT_MAX) err_cnt <= err_cnt + ERR_CNT_W'(1);
      if (!err_flag) first_err_addr <= pipe_addr;
    end
  end

endmodule

// File: tb/tb_ram_rd_chk.sv
// Bench for ram_rd_chk: three checkers share one RAM image (1-cycle RAM with
// RD_LAT=1, 2-cycle RAM with RD_LAT=2, 2-cycle RAM with RD_LAT=1) plus a
// separate checker fed all-wrong data for counter saturation.
module tb_ram_rd_chk;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_flag = 1'b0;
  logic rd_flag_s = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [DEPTH];

  logic en_a, en_b, en_c, en_s;
  logic [5:0] addr_a, addr_b, addr_c, addr_s;
  logic [7:0] rdata_a, rdata_b, rdata_c, rdata_s, p1_b, p1_c;
  logic busy_a, busy_b, busy_c, busy_s, done_a, done_b, done_c, done_s;
  logic eflag_a, eflag_b, eflag_c, eflag_s, ovr_a, ovr_b, ovr_c, ovr_s;
  logic [15:0] ecnt_a, ecnt_b, ecnt_c, ecnt_s;
  logic [5:0] first_a, first_b, first_c, first_s;

  ram_rd_chk #(.RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .rd_flag(rd_flag), .ram_rd_en(en_a),
    .ram_rd_addr(addr_a), .ram_rd_data(rdata_a), .chk_busy(busy_a), .chk_done(done_a),
    .err_flag(eflag_a), .err_cnt(ecnt_a), .first_err_addr(first_a), .ovr_flag(ovr_a));
  ram_rd_chk #(.RD_LAT(2)) dut_b (.clk(clk), .rst(rst), .rd_flag(rd_flag), .ram_rd_en(en_b),
    .ram_rd_addr(addr_b), .ram_rd_data(rdata_b), .chk_busy(busy_b), .chk_done(done_b),
    .err_flag(eflag_b), .err_cnt(ecnt_b), .first_err_addr(first_b), .ovr_flag(ovr_b));
  ram_rd_chk #(.RD_LAT(1)) dut_c (.clk(clk), .rst(rst), .rd_flag(rd_flag), .ram_rd_en(en_c),
    .ram_rd_addr(addr_c), .ram_rd_data(rdata_c), .chk_busy(busy_c), .chk_done(done_c),
    .err_flag(eflag_c), .err_cnt(ecnt_c), .first_err_addr(first_c), .ovr_flag(ovr_c));
  ram_rd_chk #(.RD_LAT(1)) dut_s (.clk(clk), .rst(rst), .rd_flag(rd_flag_s), .ram_rd_en(en_s),
    .ram_rd_addr(addr_s), .ram_rd_data(rdata_s), .chk_busy(busy_s), .chk_done(done_s),
    .err_flag(eflag_s), .err_cnt(ecnt_s), .first_err_addr(first_s), .ovr_flag(ovr_s));

  // RAM models; idle-cycle data is random garbage that must be ignored.
  always @(posedge clk) rdata_a <= en_a ? mem[addr_a] : 8'($urandom);
  always @(posedge clk) begin
    if (en_b) p1_b <= mem[addr_b];
    rdata_b <= p1_b;
  end
  always @(posedge clk) begin
    if (en_c) p1_c <= mem[addr_c];
    rdata_c <= p1_c;
  end
  always @(posedge clk) rdata_s <= en_s ? ({2'b00, addr_s} ^ 8'hFF) : 8'($urandom);

  int checks = 0;
  int errors = 0;

  // Reference model of the sticky error status for matched-latency checkers.
  int m_cnt = 0;
  bit m_flag = 1'b0;
  int m_first = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_flag = 1'b0;
    m_first = 0;
  endtask

  task automatic model_pass();
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] !== 8'(a)) begin
        if (!m_flag) m_first = a;
        m_flag = 1'b1;
        m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      end
    end
  endtask

  task automatic fill_clean();
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'(a);
  endtask

  // One pass observed over a fixed 80-cycle window from the start edge.
  // Tick k is inside READ cycle k. ovr_at > 0 re-raises rd_flag at READ cycle ovr_at.
  task automatic run_pass(input int ovr_at, output int n_en, output bit order_ok,
                          output int lat_a, output int lat_b, output int dones_a,
                          output int dones_b, output int busy_cyc);
    n_en = 0; order_ok = 1'b1; lat_a = -1; lat_b = -1;
    dones_a = 0; dones_b = 0; busy_cyc = 0;
    tick();
    rd_flag = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (ovr_at > 0 && k == ovr_at - 3) rd_flag = 1'b0;
      if (ovr_at > 0 && k == ovr_at) rd_flag = 1'b1;
      if (en_a) begin
        if (addr_a !== 6'(n_en)) order_ok = 1'b0;
        n_en++;
      end
      if (busy_a) busy_cyc++;
      if (done_a) begin dones_a++; if (lat_a < 0) lat_a = k; end
      if (done_b) begin dones_b++; if (lat_b < 0) lat_b = k; end
    end
    rd_flag = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_flag = 1'b0;
    repeat (3) tick();
    checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", en_a); end
    checks++; if (addr_a !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done_a); end
    checks++; if (eflag_a !== 1'b0) begin errors++; $display("FAIL reset_eflag: got %0b want 0", eflag_a); end
    checks++; if (ecnt_a !== 16'd0) begin errors++; $display("FAIL reset_ecnt: got %0d want 0", ecnt_a); end
    checks++; if (first_a !== 6'd0) begin errors++; $display("FAIL reset_first: got %0d want 0", first_a); end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %0b want 0", ovr_a); end
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_clean_pass();
    int n_en, lat_a, lat_b, dones_a, dones_b, busy_cyc;
    bit order_ok;
    fill_clean();
    run_pass(0, n_en, order_ok, lat_a, lat_b, dones_a, dones_b, busy_cyc);
    model_pass();
    checks++; if (n_en != DEPTH) begin errors++; $display("FAIL clean_en_count: got %0d want %0d", n_en, DEPTH); end
    checks++; if (!order_ok) begin errors++; $display("FAIL clean_addr_order: got out-of-order want 0..%0d", DEPTH - 1); end
    checks++; if (lat_a != DEPTH + 2) begin errors++; $display("FAIL clean_done_lat: got %0d want %0d", lat_a, DEPTH + 2); end
    checks++; if (busy_cyc != DEPTH + 2) begin errors++; $display("FAIL clean_busy_len: got %0d want %0d", busy_cyc, DEPTH + 2); end
    checks++; if (dones_a != 1) begin errors++; $display("FAIL clean_done_count: got %0d want 1", dones_a); end
    checks++; if (ecnt_a !== 16'(m_cnt)) begin errors++; $display("FAIL clean_ecnt: got %0d want %0d", ecnt_a, m_cnt); end
    checks++; if (eflag_a !== m_flag) begin errors++; $display("FAIL clean_eflag: got %0b want %0b", eflag_a, m_flag); end
    checks++; if (lat_b != DEPTH + 3) begin errors++; $display("FAIL lat2_done_lat: got %0d want %0d", lat_b, DEPTH + 3); end
    checks++; if (dones_b != 1) begin errors++; $display("FAIL lat2_done_count: got %0d want 1", dones_b); end
    checks++; if (ecnt_b !== 16'(m_cnt)) begin errors++; $display("FAIL lat2_ecnt: got %0d want %0d", ecnt_b, m_cnt); end
    checks++; if (ecnt_c === 16'd0 || eflag_c !== 1'b1) begin errors++; $display("FAIL lat_mismatch_detect: got ecnt %0d flag %0b want nonzero", ecnt_c, eflag_c); end
  endtask

  task automatic test_fault();
    int n_en, lat_a, lat_b, dones_a, dones_b, busy_cyc;
    bit order_ok;
    fill_clean();
    mem[5] = 8'hFF;
    mem[40] = 8'hFF;
    run_pass(0, n_en, order_ok, lat_a, lat_b, dones_a, dones_b, busy_cyc);
    model_pass();
    checks++; if (ecnt_a !== 16'(m_cnt)) begin errors++; $display("FAIL fault_ecnt: got %0d want %0d", ecnt_a, m_cnt); end
    checks++; if (first_a !== 6'(m_first)) begin errors++; $display("FAIL fault_first: got %0d want %0d", first_a, m_first); end
    checks++; if (eflag_a !== m_flag) begin errors++; $display("FAIL fault_eflag: got %0b want %0b", eflag_a, m_flag); end
    checks++; if (ecnt_b !== 16'(m_cnt) || first_b !== 6'(m_first)) begin errors++; $display("FAIL fault_lat2: got cnt %0d first %0d want %0d %0d", ecnt_b, first_b, m_cnt, m_first); end
    fill_clean();
    run_pass(0, n_en, order_ok, lat_a, lat_b, dones_a, dones_b, busy_cyc);
    model_pass();
    checks++; if (ecnt_a !== 16'(m_cnt)) begin errors++; $display("FAIL fault_clean_ecnt: got %0d want %0d", ecnt_a, m_cnt); end
    checks++; if (first_a !== 6'(m_first)) begin errors++; $display("FAIL fault_clean_first: got %0d want %0d", first_a, m_first); end
  endtask

  task automatic test_random();
    int n_en, lat_a, lat_b, dones_a, dones_b, busy_cyc, nbad, a;
    bit order_ok;
    for (int p = 0; p < 4; p++) begin
      fill_clean();
      nbad = $urandom_range(0, 6);
      for (int i = 0; i < nbad; i++) begin
        a = $urandom_range(0, DEPTH - 1);
        mem[a] = 8'(a) ^ 8'($urandom_range(1, 255));
      end
      run_pass(0, n_en, order_ok, lat_a, lat_b, dones_a, dones_b, busy_cyc);
      model_pass();
      checks++; if (ecnt_a !== 16'(m_cnt)) begin errors++; $display("FAIL rand_ecnt p%0d: got %0d want %0d", p, ecnt_a, m_cnt); end
      checks++; if (first_a !== 6'(m_first) || eflag_a !== m_flag) begin errors++; $display("FAIL rand_first p%0d: got %0d/%0b want %0d/%0b", p, first_a, eflag_a, m_first, m_flag); end
      checks++; if (ecnt_b !== 16'(m_cnt)) begin errors++; $display("FAIL rand_lat2_ecnt p%0d: got %0d want %0d", p, ecnt_b, m_cnt); end
    end
  endtask

  task automatic test_overrun();
    int n_en, lat_a, lat_b, dones_a, dones_b, busy_cyc;
    bit order_ok;
    fill_clean();
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL ovr_before: got %0b want 0", ovr_a); end
    run_pass(10, n_en, order_ok, lat_a, lat_b, dones_a, dones_b, busy_cyc);
    model_pass();
    checks++; if (ovr_a !== 1'b1 || ovr_b !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %0b/%0b want 1", ovr_a, ovr_b); end
    checks++; if (n_en != DEPTH || !order_ok) begin errors++; $display("FAIL ovr_en_count: got %0d want %0d", n_en, DEPTH); end
    checks++; if (dones_a != 1 || lat_a != DEPTH + 2) begin errors++; $display("FAIL ovr_done: got %0d at %0d want 1 at %0d", dones_a, lat_a, DEPTH + 2); end
    checks++; if (ecnt_a !== 16'(m_cnt)) begin errors++; $display("FAIL ovr_ecnt: got %0d want %0d", ecnt_a, m_cnt); end
  endtask

  task automatic test_reset_mid();
    int n_en, lat_a, lat_b, dones_a, dones_b, busy_cyc, en_seen, done_seen;
    bit order_ok;
    fill_clean();
    tick();
    rd_flag = 1'b1;
    for (int k = 1; k <= 20; k++) tick();
    rst = 1'b1;
    tick();
    checks++; if (en_a !== 1'b0 || addr_a !== 6'd0) begin errors++; $display("FAIL midrst_en: got %0b addr %0d want 0", en_a, addr_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b/%0b want 0", busy_a, done_a); end
    checks++; if (eflag_a !== 1'b0 || ecnt_a !== 16'd0 || first_a !== 6'd0 || ovr_a !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %0b %0d %0d %0b want 0", eflag_a, ecnt_a, first_a, ovr_a); end
    rst = 1'b0;
    model_reset();
    en_seen = 0; done_seen = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (en_a) en_seen++;
      if (done_a) done_seen++;
    end
    checks++; if (en_seen != 0 || done_seen != 0) begin errors++; $display("FAIL midrst_no_start: got %0d en %0d done want 0", en_seen, done_seen); end
    rd_flag = 1'b0;
    tick();
    run_pass(0, n_en, order_ok, lat_a, lat_b, dones_a, dones_b, busy_cyc);
    model_pass();
    checks++; if (n_en != DEPTH || dones_a != 1) begin errors++; $display("FAIL midrst_restart: got %0d en %0d done want %0d 1", n_en, dones_a, DEPTH); end
    checks++; if (ecnt_a !== 16'(m_cnt)) begin errors++; $display("FAIL midrst_ecnt: got %0d want %0d", ecnt_a, m_cnt); end
  endtask

  task automatic test_saturation();
    int sat_model;
    bit got_done;
    sat_model = 0;
    for (int p = 1; p <= 1025; p++) begin
      tick();
      rd_flag_s = 1'b1;
      got_done = 1'b0;
      for (int k = 0; k < 100 && !got_done; k++) begin
        tick();
        if (done_s) got_done = 1'b1;
      end
      rd_flag_s = 1'b0;
      if (!got_done) begin
        checks++; errors++;
        $display("FAIL sat_timeout pass %0d: got no chk_done want done", p);
        break;
      end
      sat_model = (sat_model + DEPTH > 65535) ? 65535 : sat_model + DEPTH;
      if (p >= 1023) begin
        checks++; if (ecnt_s !== 16'(sat_model)) begin errors++; $display("FAIL sat_ecnt pass %0d: got %0d want %0d", p, ecnt_s, sat_model); end
      end
    end
    checks++; if (eflag_s !== 1'b1 || first_s !== 6'd0) begin errors++; $display("FAIL sat_flags: got %0b/%0d want 1/0", eflag_s, first_s); end
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_fault();
    test_random();
    test_overrun();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
